// File: rtl/hwpe_stream_tcdm_req_slice_pkg.sv
// Shared constants for the HWPE stream TCDM request slice.
package hwpe_stream_package;

    localparam int unsigned HWPE_STREAM_TCDM_AW = 32;
    localparam int unsigned HWPE_STREAM_TCDM_DW = 32;
    localparam int unsigned HWPE_STREAM_TCDM_BW = HWPE_STREAM_TCDM_DW / 8;

    // Default bound on granted requests still waiting for their r_valid.
    localparam int unsigned HWPE_STREAM_TCDM_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/hwpe_stream_tcdm_req_slice_if.sv
// TCDM request/response bundle; the master drives requests, the slave answers.
interface hwpe_stream_intf_tcdm;
    import hwpe_stream_package::*;

    logic                           req;
    logic                           gnt;
    logic [HWPE_STREAM_TCDM_AW-1:0] add;
    logic                           wen;
    logic [HWPE_STREAM_TCDM_BW-1:0] be;
    logic [HWPE_STREAM_TCDM_DW-1:0] data;
    logic [HWPE_STREAM_TCDM_DW-1:0] r_data;
    logic                           r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );

endinterface

// File: rtl/hwpe_stream_tcdm_req_slice_skid.sv
// Two-entry FIFO holding request payloads between the slave and master sides.
// The head slot is never overwritten while occupied, so the presented payload
// stays stable until it is popped.
module hwpe_stream_tcdm_req_skid
    import hwpe_stream_package::*;
(
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [HWPE_STREAM_TCDM_AW-1:0] add_i,
    input  logic                           wen_i,
    input  logic [HWPE_STREAM_TCDM_BW-1:0] be_i,
    input  logic [HWPE_STREAM_TCDM_DW-1:0] data_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [HWPE_STREAM_TCDM_AW-1:0] add_o,
    output logic                           wen_o,
    output logic [HWPE_STREAM_TCDM_BW-1:0] be_o,
    output logic [HWPE_STREAM_TCDM_DW-1:0] data_o
);

    struct packed {
        logic [HWPE_STREAM_TCDM_AW-1:0] add;
        logic                           wen;
        logic [HWPE_STREAM_TCDM_BW-1:0] be;
        logic [HWPE_STREAM_TCDM_DW-1:0] data;
    } mem_q [2], wr_entry, rd_entry;

    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    // Pack the incoming payload into one entry.
    always_comb begin
        wr_entry      = '0;
        wr_entry.add  = add_i;
        wr_entry.wen  = wen_i;
        wr_entry.be   = be_i;
        wr_entry.data = data_i;
    end

    assign rd_entry = mem_q[rd_ptr_q];
    assign add_o    = rd_entry.add;
    assign wen_o    = rd_entry.wen;
    assign be_o     = rd_entry.be;
    assign data_o   = rd_entry.data;
    assign full_o   = (count_q == 2'd2);
    assign empty_o  = (count_q == 2'd0);

    // Storage, pointers and occupancy; a flush empties the FIFO but leaves payloads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wr_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hwpe_stream_tcdm_req_slice.sv
// Registered TCDM request slice: a 2-entry skid buffer on the request path,
// a bound on outstanding reads, and pass-through responses.
module hwpe_stream_tcdm_req_slice
    import hwpe_stream_package::*;
#(
    parameter int unsigned MAX_OUTSTANDING = HWPE_STREAM_TCDM_MAX_OUTSTANDING
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    hwpe_stream_intf_tcdm.slave  tcdm_slave,
    hwpe_stream_intf_tcdm.master tcdm_master,
    output logic                 busy_o
);

    localparam int unsigned      OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0]    OUT_MAX = OW'(MAX_OUTSTANDING);

    logic          ready_q;
    logic [OW-1:0] out_q;
    logic          full;
    logic          empty;
    logic          slave_gnt;
    logic          master_req;
    logic          push;
    logic          pop;

    // Holds slave gnt low until the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ready_q <= 1'b0;
        else         ready_q <= 1'b1;
    end

    // Grant depends only on state and the flush, never on the incoming req.
    assign slave_gnt      = ready_q & ~full & ~clear_i;
    assign tcdm_slave.gnt = slave_gnt;
    assign push           = tcdm_slave.req & slave_gnt;

    // A request is presented only while the outstanding budget has room.
    assign master_req      = ~empty & (out_q < OUT_MAX) & ~clear_i;
    assign tcdm_master.req = master_req;
    assign pop             = master_req & tcdm_master.gnt;

    hwpe_stream_tcdm_req_skid i_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .pop_i   (pop),
        .add_i   (tcdm_slave.add),
        .wen_i   (tcdm_slave.wen),
        .be_i    (tcdm_slave.be),
        .data_i  (tcdm_slave.data),
        .full_o  (full),
        .empty_o (empty),
        .add_o   (tcdm_master.add),
        .wen_o   (tcdm_master.wen),
        .be_o    (tcdm_master.be),
        .data_o  (tcdm_master.data)
    );

    assign tcdm_slave.r_valid = tcdm_master.r_valid;
    assign tcdm_slave.r_data  = tcdm_master.r_data;

    // Outstanding tracker: survives a flush; a stray r_valid at zero is ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q <= '0;
        end else if (pop && !tcdm_master.r_valid) begin
            out_q <= out_q + OW'(1);
        end else if (!pop && tcdm_master.r_valid && (out_q != '0)) begin
            out_q <= out_q - OW'(1);
        end
    end

    assign busy_o = ~empty | (out_q != '0);

endmodule

// File: doc/hwpe_stream_tcdm_req_slice.md
HWPE_STREAM_TCDM_REQ_SLICE -- requirements
Module: hwpe_stream_tcdm_req_slice

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of master-granted requests still awaiting r_valid (range 1..15).
REQ-002 Port clk_i SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_ni SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port clear_i SHALL be an input, 1 bit: synchronous flush, active-high.
REQ-005 Port tcdm_slave SHALL be an hwpe_stream_intf_tcdm.slave, 32-bit data: the upstream request source, with req/add/wen/be/data in and gnt/r_valid/r_data out.
REQ-006 Port tcdm_master SHALL be an hwpe_stream_intf_tcdm.master, 32-bit data: the downstream memory side.
REQ-007 Port busy_o SHALL be an output, 1 bit: high while the buffer is non-empty or any request is outstanding.

Function
REQ-008 The request path SHALL be a 2-entry skid buffer (FIFO order) holding {add, wen, be, data}.
REQ-009 tcdm_slave.gnt SHALL equal (buffer count < 2), driven from registers only, with no combinational dependence on tcdm_slave.req.
REQ-010 A slave transfer (req & gnt) at edge t SHALL write the buffer tail; its payload SHALL appear on the master side no earlier than the cycle after edge t (1-cycle minimum latency).
REQ-011 tcdm_master.req SHALL equal (count > 0) & (outstanding < MAX_OUTSTANDING), with add/wen/be/data taken from the buffer head.
REQ-012 Master req & gnt SHALL pop the head and increment the outstanding counter.
REQ-013 Push and pop in the same cycle SHALL leave the count unchanged, giving full throughput at one request per cycle.
REQ-014 Once asserted, tcdm_master.req and its payload SHALL stay stable until gnt, unless clear_i is asserted.
REQ-015 tcdm_slave.r_valid and r_data SHALL be combinational pass-throughs of tcdm_master.r_valid and r_data.
REQ-016 Each master r_valid SHALL decrement the outstanding counter; a grant and an r_valid in the same cycle SHALL leave it unchanged.
REQ-017 When outstanding == MAX_OUTSTANDING, master req SHALL be held low, so the buffer fills and slave gnt drops.
REQ-018 The outstanding counter SHALL be $clog2(MAX_OUTSTANDING+1) bits wide and SHALL never wrap; an r_valid arriving while it is 0 SHALL be forwarded with the counter held at 0.
REQ-019 clear_i SHALL empty the buffer in the next cycle and drop master req.
REQ-020 clear_i SHALL NOT reset the outstanding counter; pending responses SHALL still be forwarded and counted down.
REQ-021 While clear_i is high, slave gnt SHALL be 0 and no push SHALL occur.

Reset
REQ-022 On rst_ni low, buffer count and outstanding counter SHALL be 0 and payload registers SHALL be 0.
REQ-023 During reset, slave gnt SHALL be 0 and then 1 from the first cycle after release.
REQ-024 During reset, master req SHALL be 0 and busy_o SHALL be 0.
REQ-025 Reset asserted mid-transfer SHALL discard all buffered and outstanding state immediately (asynchronously).

Structure
REQ-026 No new typedefs SHALL be added; the buffer entry SHALL be a local struct.
REQ-027 MAX_OUTSTANDING's default SHALL be added to hwpe_stream_package as a constant.
REQ-028 One sub-module, hwpe_stream_tcdm_req_skid (the 2-entry request buffer), SHALL be used, so the outstanding tracker stays in the top.

Verification
REQ-029 Streaming: slave req held high with master gnt always 1 and r_valid one cycle after gnt, 8 reads to addresses 0x00..0x1C -> 8 slave gnts in 8 consecutive cycles, master add sequence 0x00..0x1C in order, 8 r_valid forwarded.
REQ-030 Backpressure: master gnt = 0 for 5 cycles with slave req high -> exactly 2 slave grants then gnt low; master add/payload stable throughout; on master gnt = 1 the buffer drains in order.
REQ-031 Outstanding limit: MAX_OUTSTANDING = 4, master gnt = 1, r_valid withheld -> exactly 4 master grants, then master req low and busy_o = 1; one r_valid -> exactly one further master grant.
REQ-032 Clear: 2 entries buffered and 3 outstanding, clear_i pulsed for 1 cycle -> next cycle master req = 0 and buffer empty; 3 later r_valid forwarded; busy_o falls after the third.
REQ-033 Reset mid-run: rst_ni asserted with 2 entries buffered -> master req = 0, slave gnt = 0 and busy_o = 0 within the same cycle; after release slave gnt = 1.
REQ-034 Simultaneous events: master gnt and r_valid in the same cycle at outstanding = 2 -> counter stays 2.
